// File: rtl/ctrl_pipe_pkg.sv
// Shared types and constants for the controlled pipeline chain.
// Each stage register is steered by one stage_act_e action per cycle.
package ctrl_pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    HOLD   = 2'd1,
    BUBBLE = 2'd2,
    CLEAR  = 2'd3
  } stage_act_e;

  // Bits needed to encode 0..n inclusive, i.e. clog2(n+1), never below 1.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) <= n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/ctrl_pipe_chain_if.sv
// Bundle of control, input and observation signals of the pipeline chain.
// The master side drives the chain, the slave side is the chain itself.
interface ctrl_pipe_chain_if
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);

  localparam int IDX_W = idx_width(DEPTH);

  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_ready;
  logic                   stall_en;
  logic [IDX_W-1:0]       stall_stage;
  logic                   flush_en;
  logic [IDX_W-1:0]       flush_stage;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH*WIDTH-1:0] stage_data;
  logic                   tail_valid;
  logic [WIDTH-1:0]       tail_data;
  logic [IDX_W-1:0]       count;

  modport master (
    output in_valid, in_data, stall_en, stall_stage, flush_en, flush_stage,
    input  in_ready, stage_valid, stage_data, tail_valid, tail_data, count
  );

  modport slave (
    input  in_valid, in_data, stall_en, stall_stage, flush_en, flush_stage,
    output in_ready, stage_valid, stage_data, tail_valid, tail_data, count
  );

endinterface

// File: rtl/ctrl_pipe_slot.sv
// One stage register of the chain: loads, holds, or drops to an empty
// (RESET_VAL, invalid) slot as commanded by its action.
module ctrl_pipe_slot
  import ctrl_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clock,
  input  stage_act_e       action,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid_q,
  output logic [WIDTH-1:0] data_q
);

  logic             valid_d;
  logic [WIDTH-1:0] data_d;

  // Next-state select; an invalid slot always carries RESET_VAL.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    case (action)
      LOAD: begin
        valid_d = load_valid;
        data_d  = load_valid ? load_data : RESET_VAL;
      end
      HOLD: begin
        valid_d = valid_q;
        data_d  = data_q;
      end
      BUBBLE: begin
        valid_d = 1'b0;
        data_d  = RESET_VAL;
      end
      CLEAR: begin
        valid_d = 1'b0;
        data_d  = RESET_VAL;
      end
      default: begin
        valid_d = 1'b0;
        data_d  = RESET_VAL;
      end
    endcase
  end

  // Stage state register.
  always_ff @(posedge clock) begin
    valid_q <= valid_d;
    data_q  <= data_d;
  end

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Shift pipeline of DEPTH stages with per-cycle stall and flush of the
// youngest stages; stage 1 is youngest, stage DEPTH retires.
module ctrl_pipe_chain
  import ctrl_pipe_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                 clock,
  input  logic                 reset,
  ctrl_pipe_chain_if.slave     bus
);

  localparam int               IDX_W     = idx_width(DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

  logic [IDX_W-1:0]       stall_lim_s;
  logic [IDX_W-1:0]       flush_lim_s;
  stage_act_e             act_s [DEPTH];
  logic [DEPTH-1:0]       valid_s;
  logic [DEPTH*WIDTH-1:0] data_s;
  logic [IDX_W-1:0]       count_s;

  // Disabled requests map to 0 (no stage affected); oversize requests saturate.
  function automatic logic [IDX_W-1:0] clamp_idx(input logic en, input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] r;
    if (!en) begin
      r = IDX_W'(0);
    end else if (idx > DEPTH_IDX) begin
      r = DEPTH_IDX;
    end else begin
      r = idx;
    end
    return r;
  endfunction

  // Per-stage action decode; k is the 0-based index of stage k+1.
  always_comb begin
    stall_lim_s = clamp_idx(bus.stall_en, bus.stall_stage);
    flush_lim_s = clamp_idx(bus.flush_en, bus.flush_stage);
    for (int k = 0; k < DEPTH; k++) begin
      if (reset) begin
        act_s[k] = CLEAR;
      end else if (IDX_W'(k) < flush_lim_s) begin
        act_s[k] = CLEAR;
      end else if (IDX_W'(k) < stall_lim_s) begin
        act_s[k] = HOLD;
      end else if ((stall_lim_s != IDX_W'(0)) && (IDX_W'(k) == stall_lim_s)) begin
        // First stage above the held group: its feeder is frozen, so it empties.
        act_s[k] = BUBBLE;
      end else begin
        act_s[k] = LOAD;
      end
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_slot
    logic             ld_valid_s;
    logic [WIDTH-1:0] ld_data_s;

    if (k == 0) begin : g_head
      assign ld_valid_s = bus.in_valid;
      assign ld_data_s  = bus.in_data;
    end else begin : g_body
      assign ld_valid_s = valid_s[k-1];
      assign ld_data_s  = data_s[(k-1)*WIDTH +: WIDTH];
    end

    ctrl_pipe_slot #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_slot (
      .clock      (clock),
      .action     (act_s[k]),
      .load_valid (ld_valid_s),
      .load_data  (ld_data_s),
      .valid_q    (valid_s[k]),
      .data_q     (data_s[k*WIDTH +: WIDTH])
    );
  end

  // Occupancy count over the registered valid bits.
  always_comb begin
    count_s = IDX_W'(0);
    for (int i = 0; i < DEPTH; i++) begin
      count_s = count_s + IDX_W'(valid_s[i]);
    end
  end

  assign bus.in_ready    = !bus.stall_en && !reset;
  assign bus.stage_valid = valid_s;
  assign bus.stage_data  = data_s;
  assign bus.tail_valid  = valid_s[DEPTH-1];
  assign bus.tail_data   = data_s[(DEPTH-1)*WIDTH +: WIDTH];
  assign bus.count       = count_s;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed bench for ctrl_pipe_chain (WIDTH=32, DEPTH=4) with hand-computed
// stage contents; stage_data is written as {stage4, stage3, stage2, stage1}.
module tb_ctrl_pipe_chain;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  ctrl_pipe_chain_if #(.WIDTH(32), .DEPTH(4)) bus ();

  ctrl_pipe_chain #(
    .WIDTH     (32),
    .DEPTH     (4),
    .RESET_VAL (32'h0000_0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [3:0] ev, input logic [127:0] ed,
                           input logic [2:0] ec);
    chk({tag, " stage_valid"}, bus.stage_valid, ev);
    chk({tag, " stage_data"},  bus.stage_data,  ed);
    chk({tag, " count"},       bus.count,       ec);
    chk({tag, " tail_valid"},  bus.tail_valid,  ev[3]);
    chk({tag, " tail_data"},   bus.tail_data,   ed[127:96]);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic v, input logic [31:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = 32'h0;
    bus.stall_en    = 1'b0;
    bus.stall_stage = 3'd0;
    bus.flush_en    = 1'b0;
    bus.flush_stage = 3'd0;
    step();
    step();
    chk_state("reset", 4'b0000, 128'h0, 3'd0);
    chk("ready_in_reset", bus.in_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("ready_after_reset", bus.in_ready, 1'b1);

    // Fill: first payload reaches the tail after the fourth edge.
    push(1'b1, 32'h1000);
    chk_state("fill1", 4'b0001, 128'h00000000_00000000_00000000_00001000, 3'd1);
    push(1'b1, 32'h1004);
    push(1'b1, 32'h1008);
    push(1'b1, 32'h100C);
    chk_state("fill4", 4'b1111, 128'h00001000_00001004_00001008_0000100C, 3'd4);

    // Stall S=2: stages 1..2 hold, stage 3 bubbles, stage 4 takes B, A retires.
    bus.stall_en    = 1'b1;
    bus.stall_stage = 3'd2;
    bus.in_valid    = 1'b1;
    bus.in_data     = 32'h2000;
    #1;
    chk("ready_stall", bus.in_ready, 1'b0);
    step();
    chk_state("stall2", 4'b1011, 128'h00001004_00000000_00001008_0000100C, 3'd3);

    bus.stall_en = 1'b0;
    bus.stall_stage = 3'd0;
    push(1'b1, 32'h1010);
    chk_state("post_stall", 4'b0111, 128'h00000000_00001008_0000100C_00001010, 3'd3);
    push(1'b1, 32'h1014);
    chk_state("refull", 4'b1111, 128'h00001008_0000100C_00001010_00001014, 3'd4);

    // Flush F=2 with input present: input discarded, stages 1..2 cleared.
    bus.flush_en    = 1'b1;
    bus.flush_stage = 3'd2;
    bus.in_valid    = 1'b1;
    bus.in_data     = 32'h3000;
    #1;
    chk("ready_flush", bus.in_ready, 1'b1);
    step();
    chk_state("flush2", 4'b1100, 128'h0000100C_00001010_00000000_00000000, 3'd2);

    bus.flush_en    = 1'b0;
    bus.flush_stage = 3'd0;
    push(1'b1, 32'h1018);
    chk_state("refill1", 4'b1001, 128'h00001010_00000000_00000000_00001018, 3'd2);
    push(1'b1, 32'h101C);
    push(1'b1, 32'h1020);
    push(1'b1, 32'h1024);
    chk_state("refill4", 4'b1111, 128'h00001018_0000101C_00001020_00001024, 3'd4);

    // Flush F=1 together with stall S=3.
    bus.flush_en    = 1'b1;
    bus.flush_stage = 3'd1;
    bus.stall_en    = 1'b1;
    bus.stall_stage = 3'd3;
    push(1'b1, 32'h4000);
    chk_state("flush1_stall3", 4'b0110, 128'h00000000_0000101C_00001020_00000000, 3'd2);

    // stall_stage beyond DEPTH clamps: everything holds.
    bus.flush_en    = 1'b0;
    bus.flush_stage = 3'd0;
    bus.stall_stage = 3'd7;
    push(1'b1, 32'h5000);
    chk_state("stall_clamp", 4'b0110, 128'h00000000_0000101C_00001020_00000000, 3'd2);

    // flush_en with flush_stage 0 is a plain shift.
    bus.stall_en    = 1'b0;
    bus.stall_stage = 3'd0;
    bus.flush_en    = 1'b1;
    bus.flush_stage = 3'd0;
    push(1'b1, 32'h1028);
    chk_state("flush_zero", 4'b1101, 128'h0000101C_00001020_00000000_00001028, 3'd3);

    bus.flush_en = 1'b0;
    push(1'b1, 32'h102C);
    push(1'b1, 32'h1030);
    push(1'b1, 32'h1034);
    chk_state("full_again", 4'b1111, 128'h00001028_0000102C_00001030_00001034, 3'd4);

    // Reset wins over stall on a full chain; nothing retires afterwards.
    reset           = 1'b1;
    bus.stall_en    = 1'b1;
    bus.stall_stage = 3'd2;
    push(1'b1, 32'h6000);
    chk_state("mid_reset", 4'b0000, 128'h0, 3'd0);
    reset           = 1'b0;
    bus.stall_en    = 1'b0;
    bus.stall_stage = 3'd0;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 32'h0);
      chk_state("drain_after_reset", 4'b0000, 128'h0, 3'd0);
    end

    // flush_stage beyond DEPTH clamps: whole chain cleared.
    push(1'b1, 32'h7000);
    chk_state("pre_flush_clamp", 4'b0001, 128'h00000000_00000000_00000000_00007000, 3'd1);
    push(1'b1, 32'h7004);
    bus.flush_en    = 1'b1;
    bus.flush_stage = 3'd7;
    push(1'b1, 32'h7008);
    chk_state("flush_clamp", 4'b0000, 128'h0, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
